fwrisc_trace_fifo: RTL
======================

Name: fwrisc_trace_fifo

Overview:
- Downstream consumer of the core's per-instruction retirement trace: pc, instr, rd writeback and memory-access signals.
- Captures one record per retired instruction into a circular buffer.
- Presents records on a valid/ready stream to an off-core trace sink (debug BFM, UART dumper).
- Decouples the core from sink back-pressure, never stalls the core, and counts drops when full.

Parameters:
DEPTH, 8, buffer entries; power of two, >=2
SEQ_W, 16, width of sequence number and drop counter

Ports:
clock  in  1  core clock
reset  in  1  synchronous, active-high reset
trace_en  in  1  capture enable
pc  in  32  retiring instruction address
instr  in  32  retiring instruction word
ivalid  in  1  instruction retires this cycle
rd_waddr  in  6  destination register
rd_wdata  in  32  writeback data
rd_write  in  1  writeback occurs
maddr  in  32  memory address
mdata  in  32  memory data
mstrb  in  4  byte strobes
mwrite  in  1  store (1) / load (0)
mvalid  in  1  memory access this cycle
tr_valid  out  1  record available
tr_ready  in  1  sink accepts record
tr_seq  out  SEQ_W  record sequence number
tr_gap  out  1  records were dropped immediately before this one
tr_pc  out  32  record pc
tr_instr  out  32  record instr
tr_rd_waddr  out  6  record rd address
tr_rd_wdata  out  32  record rd data
tr_rd_write  out  1  record rd write flag
tr_mvalid  out  1  record carries a memory access
tr_maddr  out  32  record memory address
tr_mdata  out  32  record memory data
tr_mstrb  out  4  record strobes
tr_mwrite  out  1  record store flag
drop_count  out  SEQ_W  dropped records, saturating
overflow  out  1  sticky: at least one drop since reset

Behaviour:
- Reset: all outputs 0; buffer empty; seq counter 0; pending-gap clear.
- Capture event: ivalid && trace_en.
  - Assigns the current seq value to the record.
  - Seq counter increments by 1 mod 2^SEQ_W on every capture event, pushed or dropped.
  - With trace_en=0, nothing is captured and seq is frozen.
- Push:
  - Accepted when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle.
  - Simultaneous push and pop leaves count unchanged.
- Drop:
  - Occurs when count==DEPTH with no pop.
  - drop_count increments, saturating at 2^SEQ_W-1.
  - overflow sets and stays set until reset.
  - pending_gap sets.
- Gap flag: the next pushed record stores tr_gap=1, and pending_gap clears in that cycle.
- Latency: a record pushed in cycle N is visible at the stream head in cycle N+1, never the same cycle.
- Stream handshake:
  - tr_valid = (count!=0).
  - Head fields are stable while tr_valid && !tr_ready.
  - A pop occurs on tr_valid && tr_ready.
  - Read and write pointers wrap modulo DEPTH.
- Empty buffer: tr_valid=0 and tr_* hold their last values; the sink ignores them.
- Core is never back-pressured; this block has no outputs toward the core.
- Reset mid-operation: buffer flushed in the cycle after reset is sampled high; in-flight records are lost, not counted as drops.

Optional Feature:
FWRISC_TRACE_MEM_EN
- Defined:
  - mvalid latches maddr/mdata/mstrb/mwrite into a pending slot.
  - The pending slot attaches to the next capture event (tr_mvalid=1), then clears.
  - mvalid and ivalid in the same cycle: the current-cycle memory values are attached directly.
  - A second mvalid before ivalid overwrites the pending slot.
  - Pending slot cleared by reset; also cleared by a capture event whose record is dropped.
- Undefined: memory inputs ignored; tr_mvalid, tr_maddr, tr_mdata, tr_mstrb, tr_mwrite constant 0; no storage for them.

Test Plan:
1. Reset, trace_en=1, tr_ready=1, single ivalid with pc=0x100, instr=0x00500093, rd_waddr=1, rd_wdata=5, rd_write=1 -> next cycle tr_valid=1, tr_seq=0, fields match, tr_gap=0; following cycle tr_valid=0.
2. DEPTH=8, tr_ready=0, 10 consecutive ivalid -> count 8, drop_count=2, overflow=1. Then tr_ready=1, one more ivalid after the drain starts -> seq 0..7 delivered with tr_gap=0, then seq 10 delivered with tr_gap=1.
3. Full buffer, ivalid and a pop in the same cycle -> push accepted, drop_count unchanged, count stays 8.
4. trace_en=0 for 3 ivalid, then trace_en=1 for 1 ivalid -> one record delivered with tr_seq=0.
5. FWRISC_TRACE_MEM_EN: mvalid with maddr=0x2000, mdata=0xDEADBEEF, mstrb=0xF, mwrite=1, then ivalid 2 cycles later -> record has tr_mvalid=1 with those values; the next ivalid record has tr_mvalid=0.
6. Assert reset with 5 records buffered -> tr_valid=0, drop_count=0, overflow=0, next record tr_seq=0.

Source files
------------

// File: rtl/fwrisc_trace_fifo.sv
// fwrisc_trace_fifo: retirement-trace capture buffer.
// One record per retired instruction (ivalid && trace_en) is pushed into a
// DEPTH-entry circular buffer and presented on a valid/ready stream. The core
// is never stalled: a capture that finds the buffer full is dropped, counted,
// and flagged on the next record that does get in (tr_gap).
// Optional feature macro: FWRISC_TRACE_MEM_EN attaches the most recent memory
// access (pending slot, or same-cycle access) to each captured record.
module fwrisc_trace_fifo #(
  parameter int DEPTH = 8,
  parameter int SEQ_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             trace_en,
  input  logic [31:0]      pc,
  input  logic [31:0]      instr,
  input  logic             ivalid,
  input  logic [5:0]       rd_waddr,
  input  logic [31:0]      rd_wdata,
  input  logic             rd_write,
  input  logic [31:0]      maddr,
  input  logic [31:0]      mdata,
  input  logic [3:0]       mstrb,
  input  logic             mwrite,
  input  logic             mvalid,
  output logic             tr_valid,
  input  logic             tr_ready,
  output logic [SEQ_W-1:0] tr_seq,
  output logic             tr_gap,
  output logic [31:0]      tr_pc,
  output logic [31:0]      tr_instr,
  output logic [5:0]       tr_rd_waddr,
  output logic [31:0]      tr_rd_wdata,
  output logic             tr_rd_write,
  output logic             tr_mvalid,
  output logic [31:0]      tr_maddr,
  output logic [31:0]      tr_mdata,
  output logic [3:0]       tr_mstrb,
  output logic             tr_mwrite,
  output logic [SEQ_W-1:0] drop_count,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef FWRISC_TRACE_MEM_EN
  localparam int MEM_W = 70;
`else
  localparam int MEM_W = 0;
`endif
  localparam int REC_W = SEQ_W + 104 + MEM_W;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [REC_W-1:0] r_mem [DEPTH];
  logic [REC_W-1:0] r_last;
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic [SEQ_W-1:0] r_seq;
  logic [SEQ_W-1:0] r_drop;
  logic             r_ovf;
  logic             r_pgap;

  logic             w_cap;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [REC_W-1:0] w_wrec;
  logic [REC_W-1:0] w_head;

  assign w_cap  = ivalid & trace_en;
  assign w_pop  = (r_count != '0) & tr_ready;
  // A full buffer still accepts when the head leaves in the same cycle.
  assign w_push = w_cap & ((r_count != FULL) | w_pop);
  assign w_drop = w_cap & ~w_push;

  // While empty the stream fields hold the last record handed to the sink.
  assign w_head = (r_count != '0) ? r_mem[r_rd] : r_last;

  assign tr_valid   = (r_count != '0);
  assign drop_count = r_drop;
  assign overflow   = r_ovf;

`ifdef FWRISC_TRACE_MEM_EN
  // {mvalid, maddr, mdata, mstrb, mwrite}; all-zero when nothing is pending.
  logic [69:0] r_mpend;
  logic [69:0] w_mrec;

  // A same-cycle access takes precedence over the pending slot.
  assign w_mrec = mvalid ? {1'b1, maddr, mdata, mstrb, mwrite} : r_mpend;

  // Pending memory slot: consumed by any capture (pushed or dropped), else refreshed by mvalid.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mpend <= '0;
    end else if (w_cap) begin
      r_mpend <= '0;
    end else if (mvalid) begin
      r_mpend <= {1'b1, maddr, mdata, mstrb, mwrite};
    end
  end

  assign w_wrec = {r_seq, r_pgap, pc, instr, rd_waddr, rd_wdata, rd_write, w_mrec};
  assign {tr_seq, tr_gap, tr_pc, tr_instr, tr_rd_waddr, tr_rd_wdata, tr_rd_write,
          tr_mvalid, tr_maddr, tr_mdata, tr_mstrb, tr_mwrite} = w_head;
`else
  logic w_unused_mem;
  assign w_unused_mem = ^{maddr, mdata, mstrb, mwrite, mvalid};

  assign w_wrec = {r_seq, r_pgap, pc, instr, rd_waddr, rd_wdata, rd_write};
  assign {tr_seq, tr_gap, tr_pc, tr_instr, tr_rd_waddr, tr_rd_wdata, tr_rd_write} = w_head;
  assign tr_mvalid = 1'b0;
  assign tr_maddr  = '0;
  assign tr_mdata  = '0;
  assign tr_mstrb  = '0;
  assign tr_mwrite = 1'b0;
`endif

  // Record storage: data only, no reset needed since occupancy is tracked separately.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr] <= w_wrec;
    end
  end

  // Last-delivered record, shown on the stream while the buffer is empty.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_last <= '0;
    end else if (w_pop) begin
      r_last <= r_mem[r_rd];
    end
  end

  // Pointers, occupancy, sequence numbering and drop accounting.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_seq   <= '0;
      r_drop  <= '0;
      r_ovf   <= 1'b0;
      r_pgap  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + AW'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + AW'(1);
      end
      if (w_push & ~w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop & ~w_push) begin
        r_count <= r_count - CW'(1);
      end
      // Every capture consumes a sequence number, so gaps show as skipped seq values.
      if (w_cap) begin
        r_seq <= r_seq + SEQ_W'(1);
      end
      if (w_drop) begin
        if (r_drop != '1) begin
          r_drop <= r_drop + SEQ_W'(1);
        end
        r_ovf  <= 1'b1;
        r_pgap <= 1'b1;
      end else if (w_push) begin
        r_pgap <= 1'b0;
      end
    end
  end

endmodule
